// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit CPU: field layout, type-A function codes,
// multiply/divide select encodings and the NOP word.
package cpu_isa_pkg;

   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned REG_W    = 4;
   localparam int unsigned FUNCT_W  = 4;
   localparam int unsigned MD_W     = 2;

   localparam int unsigned OPCODE_LSB = 12;
   localparam int unsigned RS_LSB     = 8;
   localparam int unsigned RT_LSB     = 4;
   localparam int unsigned FUNCT_LSB  = 0;

   localparam logic [OPCODE_W-1:0] OP_TYPE_A = 4'b1111;
   localparam logic [FUNCT_W-1:0]  FUNCT_MUL = 4'b0100;
   localparam logic [FUNCT_W-1:0]  FUNCT_DIV = 4'b0101;

   localparam logic [INSTR_W-1:0]  NOP_ENC   = 16'h0000;

   typedef enum logic [MD_W-1:0] {
      MD_NONE = 2'b00,
      MD_MUL  = 2'b01,
      MD_DIV  = 2'b10
   } multiDiv_e;

   // Instruction word overlay, MSB first: opcode | rs | rt | funct
   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [REG_W-1:0]    rs;
      logic [REG_W-1:0]    rt;
      logic [FUNCT_W-1:0]  funct;
   } instrFields_t;

   // Multiply/divide select; an empty slot never requests the MD unit
   function automatic multiDiv_e mdSelect(input logic [OPCODE_W-1:0] op,
                                          input logic [FUNCT_W-1:0]  fn,
                                          input logic                valid);
      multiDiv_e sel;
      sel = MD_NONE;
      if (valid && (op == OP_TYPE_A)) begin
         if (fn == FUNCT_MUL) begin
            sel = MD_MUL;
         end else if (fn == FUNCT_DIV) begin
            sel = MD_DIV;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into control/register-file fields.
// Shared by the IF/ID stage and the hazard unit.
module instr_field_decode
   import cpu_isa_pkg::*;
(
   input  logic [INSTR_W-1:0]  instr,
   input  logic                valid,
   output logic [OPCODE_W-1:0] opcode,
   output logic [MD_W-1:0]     multiDiv,
   output logic [REG_W-1:0]    rs,
   output logic [REG_W-1:0]    rt,
   output logic [FUNCT_W-1:0]  funct
);

   instrFields_t fields;

   assign fields   = instrFields_t'(instr);
   assign opcode   = fields.opcode;
   assign rs       = fields.rs;
   assign rt       = fields.rt;
   assign funct    = fields.funct;
   assign multiDiv = MD_W'(mdSelect(fields.opcode, fields.funct, valid));

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage with IF/ID pipeline register: PC sequencing, redirect
// flush, hazard stall, memory wait-state bubbles and field decode of the held word.
module if_id_stage
   import cpu_isa_pkg::*;
#(
   parameter int unsigned           ADDR_W    = 16,
   parameter logic [ADDR_W-1:0]     RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]    NOP_INSTR = NOP_ENC
)(
   input  logic                clk,
   input  logic                rst,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic                imem_req,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                imem_ready,
   input  logic                stall,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_pc,
   output logic                id_valid,
   output logic [INSTR_W-1:0]  id_instr,
   output logic [ADDR_W-1:0]   id_pc,
   output logic [ADDR_W-1:0]   id_pc_plus2,
   output logic [OPCODE_W-1:0] opcode,
   output logic [MD_W-1:0]     multi_div,
   output logic [REG_W-1:0]    rs,
   output logic [REG_W-1:0]    rt,
   output logic [FUNCT_W-1:0]  funct,
   output logic [15:0]         fetch_count
);

   localparam int unsigned CNT_W = 16;
   localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] HALF_MASK   = ~ADDR_W'(1);

   logic [ADDR_W-1:0]  pcQ,       pcD;
   logic               validQ,    validD;
   logic [INSTR_W-1:0] instrQ,    instrD;
   logic [ADDR_W-1:0]  idPcQ,     idPcD;
   logic [CNT_W-1:0]   fetchCntQ, fetchCntD;

   // Next-state selection: redirect > stall > wait state > normal fetch
   always_comb begin
      pcD       = pcQ;
      validD    = validQ;
      instrD    = instrQ;
      idPcD     = idPcQ;
      fetchCntD = fetchCntQ;

      if (redirect) begin
         pcD    = redirect_pc & HALF_MASK;
         validD = 1'b0;
         instrD = NOP_INSTR;
      end else if (stall) begin
         pcD = pcQ;
      end else if (!imem_ready) begin
         validD = 1'b0;
         instrD = NOP_INSTR;
      end else begin
         instrD    = imem_rdata;
         idPcD     = pcQ;
         validD    = 1'b1;
         pcD       = pcQ + INSTR_BYTES;
         fetchCntD = fetchCntQ + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcQ       <= RESET_PC;
         validQ    <= 1'b0;
         instrQ    <= NOP_INSTR;
         idPcQ     <= RESET_PC;
         fetchCntQ <= '0;
      end else begin
         pcQ       <= pcD;
         validQ    <= validD;
         instrQ    <= instrD;
         idPcQ     <= idPcD;
         fetchCntQ <= fetchCntD;
      end
   end

   assign imem_addr   = pcQ;
   assign imem_req    = ~rst;
   assign id_valid    = validQ;
   assign id_instr    = instrQ;
   assign id_pc       = idPcQ;
   assign id_pc_plus2 = idPcQ + INSTR_BYTES;
   assign fetch_count = fetchCntQ;

   instr_field_decode uDecode (
      .instr    (instrQ),
      .valid    (validQ),
      .opcode   (opcode),
      .multiDiv (multi_div),
      .rs       (rs),
      .rt       (rt),
      .funct    (funct)
   );

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against a behavioural pipeline model.
module tb_if_id_stage;

   localparam logic [15:0] NOP  = 16'hF124;
   localparam logic [15:0] RPC  = 16'h0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic [15:0] imem_rdata;
   logic        imem_ready = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        id_valid;
   logic [15:0] id_instr;
   logic [15:0] id_pc;
   logic [15:0] id_pc_plus2;
   logic [3:0]  opcode;
   logic [1:0]  multi_div;
   logic [3:0]  rs;
   logic [3:0]  rt;
   logic [3:0]  funct;
   logic [15:0] fetch_count;

   logic [15:0] rom [256];
   int nAssert = 0;
   int nFail   = 0;

   // Reference state: what the stage must hold after each edge
   logic [15:0] mPc, mInstr, mIdPc, mCnt;
   logic        mValid;
   bit          mKnown = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [7:0] romIdx(input logic [15:0] a);
      return 8'(a >> 1);
   endfunction

   assign imem_rdata = rom[romIdx(imem_addr)];

   if_id_stage #(.ADDR_W(16), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
      .id_pc_plus2(id_pc_plus2), .opcode(opcode), .multi_div(multi_div),
      .rs(rs), .rt(rt), .funct(funct), .fetch_count(fetch_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model, priority rst > redirect > stall > wait > fetch
   always @(posedge clk) begin
      if (rst) begin
         mPc = RPC; mValid = 1'b0; mInstr = NOP; mIdPc = RPC; mCnt = 16'd0;
         mKnown = 1'b1;
      end else if (redirect) begin
         mPc = (redirect_pc / 16'd2) * 16'd2;
         mValid = 1'b0; mInstr = NOP;
      end else if (stall) begin
         mPc = mPc;
      end else if (!imem_ready) begin
         mValid = 1'b0; mInstr = NOP;
      end else begin
         mInstr = rom[romIdx(mPc)];
         mIdPc  = mPc;
         mValid = 1'b1;
         mPc    = 16'((32'(mPc) + 2) % 65536);
         mCnt   = 16'((32'(mCnt) + 1) % 65536);
      end
   end

   // Per-cycle comparison of every output against the model
   always @(posedge clk) begin
      #2;
      if (mKnown) begin
         logic [1:0] md;
         md = 2'd0;
         if (mValid && (mInstr / 16'd4096) == 16'd15) begin
            if ((mInstr % 16'd16) == 16'd4) md = 2'd1;
            if ((mInstr % 16'd16) == 16'd5) md = 2'd2;
         end
         chk("imem_req",    32'(imem_req),    32'(!rst));
         chk("imem_addr",   32'(imem_addr),   32'(mPc));
         chk("id_valid",    32'(id_valid),    32'(mValid));
         chk("id_instr",    32'(id_instr),    32'(mInstr));
         chk("id_pc",       32'(id_pc),       32'(mIdPc));
         chk("id_pc_plus2", 32'(id_pc_plus2), (32'(mIdPc) + 2) % 65536);
         chk("opcode",      32'(opcode),      32'(mInstr) / 4096);
         chk("rs",          32'(rs),          (32'(mInstr) / 256) % 16);
         chk("rt",          32'(rt),          (32'(mInstr) / 16) % 16);
         chk("funct",       32'(funct),       32'(mInstr) % 16);
         chk("multi_div",   32'(multi_div),   32'(md));
         chk("fetch_count", 32'(fetch_count), 32'(mCnt));
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      rom[0] = 16'h1234; rom[1] = 16'h2345; rom[2] = 16'h3456;
      rom[3] = 16'hF124; rom[4] = 16'hF125; rom[5] = 16'hF126;
      rom[6] = 16'h4567; rom[8'h20] = 16'h789A; rom[8'hFF] = 16'hF125;

      // Reset state; NOP word decodes as a multiply but the slot is empty
      cyc(); cyc();
      chk("rst_valid",  32'(id_valid),    32'd0);
      chk("rst_count",  32'(fetch_count), 32'd0);
      chk("rst_instr",  32'(id_instr),    32'hF124);
      chk("rst_md",     32'(multi_div),   32'd0);
      chk("rst_req",    32'(imem_req),    32'd0);

      rst = 1'b0; imem_ready = 1'b1;
      cyc();
      chk("f1_instr",  32'(id_instr), 32'h1234);
      chk("f1_pc",     32'(id_pc),    32'h0000);
      chk("f1_opcode", 32'(opcode),   32'h1);
      cyc(); cyc();
      chk("f3_instr",  32'(id_instr),    32'h3456);
      chk("f3_pc",     32'(id_pc),       32'h0004);
      chk("f3_count",  32'(fetch_count), 32'd3);
      chk("f3_opcode", 32'(opcode),      32'h3);
      cyc(); chk("md_mul",  32'(multi_div), 32'd1);
      cyc(); chk("md_div",  32'(multi_div), 32'd2);
      cyc(); chk("md_none", 32'(multi_div), 32'd0);

      // Two wait states: bubbles, PC held, then resume at the same PC
      imem_ready = 1'b0;
      cyc();
      chk("w1_valid", 32'(id_valid),  32'd0);
      chk("w1_instr", 32'(id_instr),  32'hF124);
      cyc();
      chk("w2_addr",  32'(imem_addr),   32'h000C);
      chk("w2_count", 32'(fetch_count), 32'd6);
      imem_ready = 1'b1;
      cyc();
      chk("wr_instr", 32'(id_instr), 32'h4567);
      chk("wr_pc",    32'(id_pc),    32'h000C);

      // Stall three cycles: everything frozen
      stall = 1'b1;
      cyc(); cyc(); cyc();
      chk("st_instr", 32'(id_instr),    32'h4567);
      chk("st_pc",    32'(id_pc),       32'h000C);
      chk("st_count", 32'(fetch_count), 32'd7);
      chk("st_addr",  32'(imem_addr),   32'h000E);

      // Redirect wins over stall; odd target is aligned
      redirect = 1'b1; redirect_pc = 16'h0041;
      cyc();
      chk("rd_addr",  32'(imem_addr), 32'h0040);
      chk("rd_valid", 32'(id_valid),  32'd0);
      redirect = 1'b0; stall = 1'b0;
      cyc();
      chk("rd_instr", 32'(id_instr), 32'h789A);
      chk("rd_pc",    32'(id_pc),    32'h0040);

      // PC wrap at the top of the address space
      redirect = 1'b1; redirect_pc = 16'hFFFF;
      cyc();
      chk("wrap_pre", 32'(imem_addr), 32'hFFFE);
      redirect = 1'b0;
      cyc();
      chk("wrap_idpc", 32'(id_pc),       32'hFFFE);
      chk("wrap_p2",   32'(id_pc_plus2), 32'h0000);
      chk("wrap_addr", 32'(imem_addr),   32'h0000);

      // Reset during stall with a competing redirect
      stall = 1'b1;
      cyc();
      rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
      cyc();
      chk("rs_addr",  32'(imem_addr),   32'h0000);
      chk("rs_valid", 32'(id_valid),    32'd0);
      chk("rs_count", 32'(fetch_count), 32'd0);
      rst = 1'b0; redirect = 1'b0; stall = 1'b0;

      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(199) == 0);
         stall       = ($urandom_range(4) == 0);
         redirect    = ($urandom_range(9) == 0);
         redirect_pc = ($urandom_range(7) == 0) ? 16'hFFFC + 16'($urandom_range(3))
                                                : 16'($urandom);
         imem_ready  = ($urandom_range(3) != 0);
         cyc();
      end

      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Instruction fetch stage plus IF/ID pipeline register for the 16-bit CPU. It holds the PC and drives the instruction-memory address. It captures the returned instruction word and splits it into opcode, multiDiv and register fields. These fields feed the control unit and register file directly. The stage honours hazard stall, branch/jump redirect and memory wait states, and inserts bubbles where required.

Parameters:
ADDR_W, 16, PC / instruction address width in bits (byte addressed)
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, encoding placed in the IF/ID register for a bubble

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
imem_addr  out  ADDR_W  fetch address (= current PC), combinational from PC
imem_req  out  1  fetch request, 1 whenever not in reset
imem_rdata  in  16  instruction word for imem_addr, combinational (async ROM)
imem_ready  in  1  1 = imem_rdata valid this cycle; 0 = wait state
stall  in  1  hazard unit: hold PC and IF/ID contents
redirect  in  1  taken branch/jump from later stage
redirect_pc  in  ADDR_W  new PC target; bit 0 ignored
id_valid  out  1  IF/ID holds a real instruction
id_instr  out  16  registered instruction word
id_pc  out  ADDR_W  PC of id_instr
id_pc_plus2  out  ADDR_W  id_pc + 2, mod 2^ADDR_W
opcode  out  4  id_instr[15:12]
multi_div  out  2  multiply/divide select for control
rs  out  4  id_instr[11:8]
rt  out  4  id_instr[7:4]
funct  out  4  id_instr[3:0]
fetch_count  out  16  count of instructions accepted into IF/ID

Behaviour:
- Reset, synchronous: pc<=RESET_PC; id_valid<=0; id_instr<=NOP_INSTR; id_pc<=RESET_PC; fetch_count<=0. imem_req=0 while rst is high.
- Per-cycle priority is rst > redirect > stall > !imem_ready > normal.
- redirect=1:
  - pc <= {redirect_pc[ADDR_W-1:1],1'b0}.
  - IF/ID is flushed: id_valid<=0, id_instr<=NOP_INSTR.
  - Redirect overrides a simultaneous stall.
  - The word fetched this cycle is discarded.
- stall=1 with no redirect: pc, id_instr, id_pc, id_valid and fetch_count all hold.
- imem_ready=0 with no stall and no redirect:
  - pc holds.
  - A bubble is inserted: id_valid<=0, id_instr<=NOP_INSTR.
  - id_pc holds.
- Normal case:
  - id_instr<=imem_rdata; id_pc<=pc; id_valid<=1.
  - pc<=pc+2, wrapping modulo 2^ADDR_W (e.g. FFFE->0000).
  - fetch_count<=fetch_count+1, wrapping at 16 bits.
- Fetch latency: an instruction at PC=A present in cycle t appears on id_* at cycle t+1.
- Decode outputs are purely combinational from id_instr:
  - opcode=id_instr[15:12].
  - multi_div = 2'b01 when opcode==4'b1111 and funct==4'b0100 (multiply).
  - multi_div = 2'b10 when opcode==4'b1111 and funct==4'b0101 (divide).
  - multi_div = 2'b00 otherwise, and always 2'b00 when id_valid=0.
- Reset mid-stall or mid-wait state: reset wins and stage state is fully reinitialised. No partial fetch survives.
- redirect during rst is ignored.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - OP_TYPE_A=4'b1111
  - FUNCT_MUL=4'b0100, FUNCT_DIV=4'b0101
  - MD_NONE=2'b00, MD_MUL=2'b01, MD_DIV=2'b10
  - NOP encoding
  - instruction field bit positions
- One natural combinational sub-module: instr_field_decode. It maps id_instr and id_valid to opcode/multi_div/rs/rt/funct and is reused by the hazard unit.
- PC/IF-ID sequencing stays in if_id_stage.

Test Plan:
- Reset, then imem returns 16'h1234,16'h2345,16'h3456 with ready=1 -> id_instr follows one cycle late; id_pc=0000,0002,0004; fetch_count=3; opcode=1,2,3.
- Fetch 16'hF124 then 16'hF125 then 16'hF126 -> multi_div=01, then 10, then 00; with id_valid forced 0 by a bubble, multi_div=00.
- stall high 3 cycles mid-stream -> PC and id_* frozen, fetch_count unchanged; stall+redirect together to 0x0041 -> pc=0x0040, id_valid=0 next cycle.
- imem_ready low 2 cycles -> two bubbles (id_valid=0, id_instr=NOP_INSTR), PC unchanged; on ready, fetch resumes at the same PC.
- PC at 16'hFFFE with normal fetch -> pc wraps to 0000; id_pc_plus2=0000. Assert rst during a stall -> pc=RESET_PC, id_valid=0, fetch_count=0 next cycle.
